pll_phase_detect: RTL and testbench
===================================

# pll_phase_detect

Digital sampled phase/frequency detector and lock monitor for the PLL feedback path. Consumes the divided feedback clock `fb_in` from the feedback divider and the reference clock `ref_in`. Both are treated as asynchronous data inputs and sampled on the fast system clock `clk`. Produces up/dn steering, a signed per-cycle phase-error measurement, and a hysteretic `locked` flag for the loop controller.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `ref_in` and `fb_in`.
- `ERR_W`, default 8: width of `phase_err`, signed; magnitude saturates at 2^(ERR_W-1)-1.
- `PHASE_TOL`, default 2: maximum |phase_err| that counts as a good sample.
- `LOCK_COUNT`, default 16: number of consecutive good samples needed to assert `locked`.
- `UNLOCK_COUNT`, default 4: number of consecutive bad samples needed to deassert `locked`.
- `REF_TIMEOUT`, default 1023: number of clk cycles without a ref edge before `ref_lost` asserts.
- `clk`, in, 1: system sampling clock; must be at least 4× the ref frequency.
- `rst_n`, in, 1: reset, asynchronous, active-low; clock `clk`.
- `enable`, in, 1: synchronous run enable.
- `ref_in`, in, 1: reference clock, asynchronous.
- `fb_in`, in, 1: divided feedback clock, asynchronous.
- `up`, out, 1: high while ref leads (measurement open).
- `dn`, out, 1: high while fb leads (measurement open).
- `phase_err`, out, ERR_W: signed; +k means ref leads by k clk cycles.
- `err_valid`, out, 1: one-cycle pulse; `phase_err` updated in the same cycle.
- `locked`, out, 1: lock indication.
- `ref_lost`, out, 1: reference absent.

## Operation
- Edge detection: each input passes through SYNC_STAGES flops, then a rising-edge detector producing `ref_edge` / `fb_edge` pulses.
- FSM states: IDLE, WAIT, REF_LEAD, FB_LEAD.
- IDLE:
  - Entered whenever `enable`=0.
  - Clears counters, `up`, `dn`, `locked`, `ref_lost`; `phase_err` holds.
  - When `enable`=1 → WAIT.
- WAIT:
  - `ref_edge` and `fb_edge` together → report 0, stay in WAIT.
  - `ref_edge` only → REF_LEAD, cnt=1.
  - `fb_edge` only → FB_LEAD, cnt=1.
- REF_LEAD (`up`=1):
  - Each cycle cnt+1.
  - `fb_edge` → report +cnt, then go to WAIT; if `ref_edge` occurs in the same cycle, go to REF_LEAD with cnt=1 instead.
  - A second `ref_edge` without `fb_edge` (cycle slip) → report +max, stay in REF_LEAD, cnt=1.
  - cnt reaching max → report +max, go to WAIT.
- FB_LEAD: mirror of REF_LEAD with `dn`=1 and negative values; -max = -(2^(ERR_W-1)-1).
- Lock update, on each report:
  - good = |err| ≤ PHASE_TOL.
  - Good sample: good_cnt+1 (saturating), bad_cnt=0.
  - Bad sample: bad_cnt+1, good_cnt=0.
  - `locked` sets when good_cnt reaches LOCK_COUNT.
  - `locked` clears when bad_cnt reaches UNLOCK_COUNT.
- ref_lost:
  - A free counter is cleared on every `ref_edge`.
  - When it reaches REF_TIMEOUT: `ref_lost`=1, `locked`=0, good_cnt=0.
  - The next `ref_edge` clears `ref_lost`.

## Timing
- Reset values: all outputs 0; FSM in IDLE; synchronizers 0.
- Input rising edge to edge pulse: SYNC_STAGES+1 clk cycles.
- `up`/`dn` are registered:
  - High from the cycle after the leading-edge pulse.
  - Through the cycle of the closing-edge pulse.
- `phase_err` magnitude = number of clk cycles between the leading and closing edge pulses.
- `err_valid` and `phase_err` are registered and appear one cycle after the closing-edge pulse.
- `locked` updates in the same cycle as the `err_valid` that causes the change.
- `enable` falling: IDLE on the next cycle; any open measurement is discarded with no report.
- `rst_n` mid-measurement: immediate return to reset values; no report.

## Structure
- Package `pll_pkg` holds:
  - The state enum `pd_state_e`.
  - A function giving the saturation value for ERR_W.
- Sub-module `edge_sync`: SYNC_STAGES synchronizer plus rising-edge pulse. Instantiated twice, once for ref and once for fb.

## Test plan
- Reset: hold `rst_n`=0 with toggling inputs → all outputs 0; after release with `enable`=1 → still no `err_valid` until the first edges.
- Ref leads: ref edge pulse at cycle 10, fb edge pulse at cycle 15 → `up` high for cycles 11–15, `err_valid` at 16 with `phase_err`=+5.
- Fb leads by 3 → `dn` high for 3 cycles, `phase_err`=-3; coincident edges → `phase_err`=0 with `up`=`dn`=0.
- Lock hysteresis:
  - 16 reports of ±1 → `locked` rises at the 16th `err_valid`.
  - 3 reports of +10 then 1 of +1 → stays locked.
  - 4 reports of +10 → `locked` falls at the 4th.
- Slip and timeout:
  - Two ref edges with no fb → report +127.
  - Stop ref → `ref_lost` after 1023 cycles and `locked`=0.
  - Restart ref → `ref_lost` clears.
- Abort: drop `enable` or assert `rst_n`=0 during REF_LEAD → no `err_valid`, `up`=0 the next cycle, all counters cleared.

Source files
------------

// File: rtl/pll_pkg.sv
// Shared types and helpers for the PLL sampled phase/frequency detector.
package pll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REF_LEAD,
    ST_FB_LEAD
  } pd_state_e;

  // Largest magnitude a signed err_w-bit phase error can report (symmetric range).
  function automatic int err_sat(input int err_w);
    return (1 << (err_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/pll_phase_detect_edge_sync.sv
// Metastability synchronizer followed by a registered rising-edge pulse.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= (sync << 1) | SYNC_STAGES'(din);
      prev  <= sync[SYNC_STAGES-1];
      pulse <= sync[SYNC_STAGES-1] & ~prev;
    end
  end

endmodule

// File: rtl/pll_phase_detect.sv
// Sampled phase/frequency detector with signed per-cycle phase error,
// hysteretic lock flag and reference-loss timeout.
module pll_phase_detect
  import pll_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int ERR_W        = 8,
  parameter int PHASE_TOL    = 2,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4,
  parameter int REF_TIMEOUT  = 1023
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    ref_in,
  input  logic                    fb_in,
  output logic                    up,
  output logic                    dn,
  output logic signed [ERR_W-1:0] phase_err,
  output logic                    err_valid,
  output logic                    locked,
  output logic                    ref_lost
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);
  localparam int TW = $clog2(REF_TIMEOUT + 1);

  localparam logic [ERR_W-1:0] MAX_U    = ERR_W'(err_sat(ERR_W));
  localparam logic [ERR_W-1:0] TOL_U    = ERR_W'(PHASE_TOL);
  localparam logic [GW-1:0]    LOCK_N   = GW'(LOCK_COUNT);
  localparam logic [BW-1:0]    UNLOCK_N = BW'(UNLOCK_COUNT);
  localparam logic [TW-1:0]    TO_MAX   = TW'(REF_TIMEOUT);

  logic ref_edge;
  logic fb_edge;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ref_in),
    .pulse (ref_edge)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (fb_in),
    .pulse (fb_edge)
  );

  pd_state_e        state;
  logic [ERR_W-1:0] cnt;
  logic [GW-1:0]    good_cnt;
  logic [BW-1:0]    bad_cnt;
  logic [TW-1:0]    to_cnt;

  logic             rpt;
  logic             rpt_neg;
  logic [ERR_W-1:0] rpt_mag;
  logic             rpt_good;
  logic [GW-1:0]    good_inc;
  logic [BW-1:0]    bad_inc;

  // A closing edge reports the count; a slip or a full count reports saturation.
  always_comb begin
    rpt     = 1'b0;
    rpt_neg = 1'b0;
    rpt_mag = '0;
    case (state)
      ST_WAIT: rpt = ref_edge & fb_edge;
      ST_REF_LEAD: begin
        rpt     = fb_edge | ref_edge | (cnt == MAX_U);
        rpt_mag = fb_edge ? cnt : MAX_U;
      end
      ST_FB_LEAD: begin
        rpt     = ref_edge | fb_edge | (cnt == MAX_U);
        rpt_mag = ref_edge ? cnt : MAX_U;
        rpt_neg = 1'b1;
      end
      default: ;
    endcase
    if (!enable) rpt = 1'b0;
  end

  assign rpt_good = (rpt_mag <= TOL_U);
  assign good_inc = (good_cnt == LOCK_N) ? good_cnt : good_cnt + GW'(1);
  assign bad_inc  = (bad_cnt == UNLOCK_N) ? bad_cnt : bad_cnt + BW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      up        <= 1'b0;
      dn        <= 1'b0;
      phase_err <= '0;
      err_valid <= 1'b0;
      locked    <= 1'b0;
      ref_lost  <= 1'b0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      to_cnt    <= '0;
    end else if (!enable) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      up        <= 1'b0;
      dn        <= 1'b0;
      err_valid <= 1'b0;
      locked    <= 1'b0;
      ref_lost  <= 1'b0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      to_cnt    <= '0;
    end else begin
      err_valid <= rpt;
      if (rpt) begin
        phase_err <= rpt_neg ? $signed(-rpt_mag) : $signed(rpt_mag);
        if (rpt_good) begin
          good_cnt <= good_inc;
          bad_cnt  <= '0;
          if (good_inc == LOCK_N) locked <= 1'b1;
        end else begin
          good_cnt <= '0;
          bad_cnt  <= bad_inc;
          if (bad_inc == UNLOCK_N) locked <= 1'b0;
        end
      end

      case (state)
        ST_IDLE: state <= ST_WAIT;
        ST_WAIT: begin
          if (ref_edge && !fb_edge) begin
            state <= ST_REF_LEAD;
            cnt   <= ERR_W'(1);
            up    <= 1'b1;
          end else if (fb_edge && !ref_edge) begin
            state <= ST_FB_LEAD;
            cnt   <= ERR_W'(1);
            dn    <= 1'b1;
          end
        end
        ST_REF_LEAD: begin
          if (ref_edge) begin
            cnt <= ERR_W'(1);
          end else if (fb_edge || cnt == MAX_U) begin
            state <= ST_WAIT;
            up    <= 1'b0;
          end else begin
            cnt <= cnt + ERR_W'(1);
          end
        end
        ST_FB_LEAD: begin
          if (fb_edge) begin
            cnt <= ERR_W'(1);
          end else if (ref_edge || cnt == MAX_U) begin
            state <= ST_WAIT;
            dn    <= 1'b0;
          end else begin
            cnt <= cnt + ERR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Reference-loss watchdog overrides any lock update made this cycle.
      if (ref_edge) begin
        to_cnt   <= '0;
        ref_lost <= 1'b0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + TW'(1);
        if (to_cnt == TO_MAX - TW'(1)) begin
          ref_lost <= 1'b1;
          locked   <= 1'b0;
          good_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pll_phase_detect.sv
// Directed bench for pll_phase_detect: vector table plus hand sequences for
// lock hysteresis, slip, reference timeout and aborts.
module tb_pll_phase_detect;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              ref_in;
  logic              fb_in;
  logic              up;
  logic              dn;
  logic signed [7:0] phase_err;
  logic              err_valid;
  logic              locked;
  logic              ref_lost;

  int n_checks = 0;
  int n_errors = 0;

  int ev_q[$];
  int ev_idx_q[$];
  int up_cnt;
  int dn_cnt;
  int first_act;
  int lock_at_ev;

  typedef struct {
    int ref_off;
    int fb_off;
    int exp_err;
    int exp_up;
    int exp_dn;
  } vec_t;

  vec_t vecs[6];

  pll_phase_detect dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .ref_in    (ref_in),
    .fb_in     (fb_in),
    .up        (up),
    .dn        (dn),
    .phase_err (phase_err),
    .err_valid (err_valid),
    .locked    (locked),
    .ref_lost  (ref_lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs are raised for two cycles at the given offsets (-1 = no pulse);
  // outputs are sampled on the falling edge before the inputs are updated.
  task automatic run_meas(input int ref_off, input int ref_off2, input int fb_off, input int len);
    ev_q.delete();
    ev_idx_q.delete();
    up_cnt     = 0;
    dn_cnt     = 0;
    first_act  = -1;
    lock_at_ev = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (err_valid) begin
        ev_q.push_back(int'(phase_err));
        ev_idx_q.push_back(i);
        lock_at_ev = int'(locked);
      end
      if (up) up_cnt++;
      if (dn) dn_cnt++;
      if ((up || dn) && first_act < 0) first_act = i;
      ref_in = (ref_off >= 0 && i >= ref_off && i < ref_off + 2) ||
               (ref_off2 >= 0 && i >= ref_off2 && i < ref_off2 + 2);
      fb_in  = (fb_off >= 0 && i >= fb_off && i < fb_off + 2);
    end
  endtask

  task automatic restart_enable();
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int lead;
    int close;
    int wait_n;
    int ev_seen;

    vecs[0] = '{ref_off: 0, fb_off: 5,  exp_err: 5,   exp_up: 5,  exp_dn: 0};
    vecs[1] = '{ref_off: 3, fb_off: 0,  exp_err: -3,  exp_up: 0,  exp_dn: 3};
    vecs[2] = '{ref_off: 0, fb_off: 0,  exp_err: 0,   exp_up: 0,  exp_dn: 0};
    vecs[3] = '{ref_off: 0, fb_off: 1,  exp_err: 1,   exp_up: 1,  exp_dn: 0};
    vecs[4] = '{ref_off: 2, fb_off: 0,  exp_err: -2,  exp_up: 0,  exp_dn: 2};
    vecs[5] = '{ref_off: 0, fb_off: 20, exp_err: 20,  exp_up: 20, exp_dn: 0};

    // Reset with toggling inputs
    rst_n  = 1'b0;
    enable = 1'b0;
    ref_in = 1'b0;
    fb_in  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ref_in = ~ref_in;
      fb_in  = (i % 3) == 0;
    end
    @(negedge clk);
    check("rst_up", int'(up), 0);
    check("rst_dn", int'(dn), 0);
    check("rst_err_valid", int'(err_valid), 0);
    check("rst_phase_err", int'(phase_err), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_ref_lost", int'(ref_lost), 0);
    ref_in = 1'b0;
    fb_in  = 1'b0;
    repeat (4) @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    run_meas(-1, -1, -1, 10);
    check("post_rst_no_valid", ev_q.size(), 0);

    // Table-driven single measurements
    foreach (vecs[k]) begin
      lead  = (vecs[k].ref_off < vecs[k].fb_off) ? vecs[k].ref_off : vecs[k].fb_off;
      close = (vecs[k].ref_off > vecs[k].fb_off) ? vecs[k].ref_off : vecs[k].fb_off;
      run_meas(vecs[k].ref_off, -1, vecs[k].fb_off, close + 9);
      check($sformatf("vec%0d_nvalid", k), ev_q.size(), 1);
      if (ev_q.size() == 1) begin
        check($sformatf("vec%0d_phase_err", k), ev_q[0], vecs[k].exp_err);
        check($sformatf("vec%0d_valid_cycle", k), ev_idx_q[0], close + 4);
      end
      check($sformatf("vec%0d_up_cycles", k), up_cnt, vecs[k].exp_up);
      check($sformatf("vec%0d_dn_cycles", k), dn_cnt, vecs[k].exp_dn);
      if (close != lead)
        check($sformatf("vec%0d_first_active", k), first_act, lead + 4);
    end

    // Cycle slip: two ref edges then fb closes the restarted measurement
    run_meas(0, 10, 12, 21);
    check("slip_nvalid", ev_q.size(), 2);
    if (ev_q.size() == 2) begin
      check("slip_sat", ev_q[0], 127);
      check("slip_after", ev_q[1], 2);
    end

    // Lock hysteresis
    restart_enable();
    for (int k = 1; k <= 16; k++) begin
      if (k % 2) run_meas(0, -1, 1, 10);
      else       run_meas(1, -1, 0, 10);
      check($sformatf("lock_acq_%0d", k), lock_at_ev, (k == 16) ? 1 : 0);
    end
    for (int k = 1; k <= 3; k++) begin
      run_meas(0, -1, 10, 19);
      check($sformatf("lock_hold_bad_%0d", k), lock_at_ev, 1);
    end
    run_meas(0, -1, 1, 10);
    check("lock_hold_good", lock_at_ev, 1);
    for (int k = 1; k <= 4; k++) begin
      run_meas(0, -1, 10, 19);
      check($sformatf("lock_drop_%0d", k), lock_at_ev, (k < 4) ? 1 : 0);
    end

    // Relock, then stop the reference
    for (int k = 1; k <= 16; k++) begin
      run_meas(0, -1, 1, 10);
      check($sformatf("relock_%0d", k), lock_at_ev, (k == 16) ? 1 : 0);
    end
    wait_n = 0;
    while (!ref_lost && wait_n < 1200) begin
      @(negedge clk);
      wait_n++;
    end
    check("ref_lost_seen", int'(ref_lost), 1);
    check("ref_lost_latency_ok", int'(wait_n >= 1010 && wait_n <= 1025), 1);
    check("ref_lost_unlock", int'(locked), 0);
    run_meas(0, -1, 0, 10);
    check("ref_restart_clear", int'(ref_lost), 0);
    check("ref_restart_nvalid", ev_q.size(), 1);

    // Abort by dropping enable mid REF_LEAD; phase_err must hold
    run_meas(0, -1, 3, 12);
    check("pre_abort_err", int'(phase_err), 3);
    ev_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (err_valid) ev_seen++;
      if (i == 7) check("en_abort_up_open", int'(up), 1);
      if (i == 9) check("en_abort_up_clear", int'(up), 0);
      ref_in = (i < 2);
      fb_in  = (i >= 10 && i < 12);
      if (i == 8) enable = 1'b0;
    end
    check("en_abort_no_valid", ev_seen, 0);
    check("en_abort_err_hold", int'(phase_err), 3);
    check("en_abort_locked", int'(locked), 0);
    enable = 1'b1;
    repeat (3) @(negedge clk);

    // Abort by reset mid REF_LEAD
    ev_seen = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (err_valid) ev_seen++;
      if (i == 7) check("rst_abort_up_open", int'(up), 1);
      ref_in = (i < 2);
      fb_in  = (i >= 10 && i < 12);
      if (i == 8) begin
        rst_n = 1'b0;
        #1;
        check("rst_abort_up", int'(up), 0);
        check("rst_abort_phase_err", int'(phase_err), 0);
      end
      if (i == 16) rst_n = 1'b1;
    end
    check("rst_abort_no_valid", ev_seen, 0);
    check("rst_abort_locked", int'(locked), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
